// File: rtl/cache_axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cache_axi_rd_arbiter_pkg
//  Brief   : Shared types and AXI encodings for the cache AXI read arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package cache_axi_rd_arbiter_pkg;

    // Arbiter sequencing: grant, address phase, data phase, return pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } rd_arb_state_t;

    // Which cache owns (or last owned) the read channel.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
    localparam logic [3:0] ARCACHE_CACHED   = 4'b1111;
    localparam logic [3:0] ARCACHE_UNCACHED = 4'b0000;

endpackage : cache_axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/cache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : cache_axi_rd_arbiter
//  Brief   : Shares one AXI4 read channel between icache and dcache. One
//            outstanding INCR burst; 32-bit beats assembled into 128 bits.
//  Revision: 1.0 - initial release
// ============================================================================
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int I_UC_BEATS = 2,
    parameter int D_UC_BEATS = 1,
    parameter int I_ARID     = 0,
    parameter int D_ARID     = 1
) (
    input  logic         clk_g,
    input  logic         resetn,
    // icache side
    input  logic         i_rd_req,
    input  logic         i_rd_uncache,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic [127:0] i_ret_data,
    // dcache side
    input  logic         d_rd_req,
    input  logic         d_rd_uncache,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic [127:0] d_ret_data,
    // AXI read address channel
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [3:0]   arcache,
    output logic         arvalid,
    input  logic         arready,
    // AXI read data channel
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [7:0] c_line_len = 8'(LINE_BEATS - 1);
    localparam logic [7:0] c_i_uc_len = 8'(I_UC_BEATS - 1);
    localparam logic [7:0] c_d_uc_len = 8'(D_UC_BEATS - 1);
    localparam logic [3:0] c_i_arid   = 4'(I_ARID);
    localparam logic [3:0] c_d_arid   = 4'(D_ARID);

    rd_arb_state_t r_state;
    rd_arb_state_t w_state_nxt;
    req_id_t       r_last_grant;
    req_id_t       r_owner;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_sel_unc;
    logic [7:0]    w_sel_len;
    logic [7:0]    r_beat_cnt;
    logic [127:0]  r_buf;
    logic          r_arvalid;
    logic [31:0]  r_araddr;
    logic [7:0]    r_arlen;
    logic [3:0]    r_arid;
    logic [3:0]    r_arcache;
    logic          w_unused;

    // Response id, status and last flag carry no control meaning here.
    assign w_unused = ^{rid, rresp, rlast};

    // State register.
    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and IDLE-cycle grant; on a tie the port not served last wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (resetn) begin
                    if (d_rd_req && (!i_rd_req || r_last_grant == REQ_I)) begin
                        w_grant_d = 1'b1;
                    end else if (i_rd_req) begin
                        w_grant_i = 1'b1;
                    end
                end
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                if (r_arvalid && arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                if (rvalid && r_beat_cnt == r_arlen) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst shape of the winning request.
    always_comb begin
        w_sel_unc = w_grant_d ? d_rd_uncache : i_rd_uncache;
        w_sel_len = c_line_len;
        if (w_sel_unc) begin
            w_sel_len = w_grant_d ? c_d_uc_len : c_i_uc_len;
        end
    end

    // Latch the granted request, run the AR handshake and assemble R beats.
    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= REQ_I;
            r_owner      <= REQ_I;
            r_arvalid    <= 1'b0;
            r_araddr     <= 32'd0;
            r_arlen      <= 8'd0;
            r_arid       <= 4'd0;
            r_arcache    <= 4'd0;
            r_beat_cnt   <= 8'd0;
            r_buf        <= 128'd0;
        end else begin
            if (w_grant_i || w_grant_d) begin
                r_owner      <= w_grant_d ? REQ_D : REQ_I;
                r_last_grant <= w_grant_d ? REQ_D : REQ_I;
                r_araddr     <= w_grant_d ? d_rd_addr : i_rd_addr;
                r_arid       <= w_grant_d ? c_d_arid : c_i_arid;
                r_arlen      <= w_sel_len;
                r_arcache    <= w_sel_unc ? ARCACHE_UNCACHED : ARCACHE_CACHED;
                r_arvalid    <= 1'b1;
            end else if (r_arvalid && arready) begin
                r_arvalid  <= 1'b0;
                r_beat_cnt <= 8'd0;
            end
            // Beats enter at the top and shift down, so a full line ends
            // with word 0 in the low 32 bits.
            if (r_state == ST_R && rvalid) begin
                r_buf      <= {rdata, r_buf[127:32]};
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    assign i_rd_rdy    = w_grant_i;
    assign d_rd_rdy    = w_grant_d;
    assign i_ret_valid = (r_state == ST_DONE) && (r_owner == REQ_I);
    assign d_ret_valid = (r_state == ST_DONE) && (r_owner == REQ_D);
    assign i_ret_data  = r_buf;
    assign d_ret_data  = r_buf;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arcache = r_arcache;
    assign arvalid = r_arvalid;
    assign rready  = (r_state == ST_R);

endmodule : cache_axi_rd_arbiter
`default_nettype wire

// File: tb/tb_cache_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cache_axi_rd_arbiter
//  Brief   : Self-checking bench for cache_axi_rd_arbiter with a
//            transaction-level reference model of arbitration and data.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cache_axi_rd_arbiter;

    logic         clk_g = 1'b0;
    logic         resetn;
    logic         i_rd_req, i_rd_uncache, d_rd_req, d_rd_uncache;
    logic [31:0]  i_rd_addr, d_rd_addr;
    logic         i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid;
    logic [127:0] i_ret_data, d_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arcache;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    int checks   = 0;
    int failures = 0;

    // Reference model state: assembled line and which port was served last.
    logic [127:0] m_buf;
    bit           m_last_d;
    logic [31:0]  fix_data [4];
    bit           use_fix;

    cache_axi_rd_arbiter dut (
        .clk_g(clk_g), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_uncache(i_rd_uncache), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_uncache(d_rd_uncache), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk_g = ~clk_g;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_g);
        resetn   = 1'b0;
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        m_buf    = '0;
        m_last_d = 1'b0;
        repeat (2) @(negedge clk_g);
        #1;
        chk("rst_arvalid", 128'(arvalid), 128'(0));
        chk("rst_rready", 128'(rready), 128'(0));
        chk("rst_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(0));
        chk("rst_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(0));
        chk("rst_araddr", 128'(araddr), 128'(0));
        chk("rst_ret_data", i_ret_data, 128'(0));
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        resetn   = 1'b1;
    endtask

    // One transaction: raise requests, expect the model's winner, act as AXI
    // slave with optional AR stall and R gaps, then check the return pulse.
    task automatic do_round(input bit want_i, input bit unc_i, input logic [31:0] addr_i,
                            input bit want_d, input bit unc_d, input logic [31:0] addr_d,
                            input int ar_delay, input int gap_max, input int abort_beat,
                            output int wait_cyc);
        bit          win_d;
        bit          w_unc;
        int          beats;
        int          n;
        int          gap;
        logic [31:0] word;
        logic [31:0] exp_addr;
        wait_cyc = 0;
        @(negedge clk_g);
        if (want_i && !i_rd_req) begin
            i_rd_addr = addr_i; i_rd_uncache = unc_i; i_rd_req = 1'b1;
        end
        if (want_d && !d_rd_req) begin
            d_rd_addr = addr_d; d_rd_uncache = unc_d; d_rd_req = 1'b1;
        end
        #1;
        chk("idle_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(0));
        while (!(i_rd_rdy || d_rd_rdy) && wait_cyc < 50) begin
            @(negedge clk_g);
            #1;
            wait_cyc++;
        end
        if (!(i_rd_rdy || d_rd_rdy)) begin
            chk("rdy_timeout", 128'(i_rd_rdy || d_rd_rdy), 128'(1));
            return;
        end
        win_d    = (i_rd_req && d_rd_req) ? !m_last_d : d_rd_req;
        m_last_d = win_d;
        chk("grant_i", 128'(i_rd_rdy), 128'(!win_d));
        chk("grant_d", 128'(d_rd_rdy), 128'(win_d));
        exp_addr = win_d ? d_rd_addr : i_rd_addr;
        w_unc    = win_d ? d_rd_uncache : i_rd_uncache;
        beats    = w_unc ? (win_d ? 1 : 2) : 4;
        n = 0;
        @(negedge clk_g);
        n++;
        if (win_d) d_rd_req = 1'b0; else i_rd_req = 1'b0;
        for (int k = 0; k <= ar_delay; k++) begin
            if (k > 0) begin
                @(negedge clk_g);
                n++;
            end
            arready = (k == ar_delay);
            #1;
            chk("ar_arvalid", 128'(arvalid), 128'(1));
            chk("ar_araddr", 128'(araddr), 128'(exp_addr));
            chk("ar_arlen", 128'(arlen), 128'(beats - 1));
            chk("ar_arid", 128'(arid), 128'(win_d));
            chk("ar_arcache", 128'(arcache), 128'(w_unc ? 4'h0 : 4'hf));
            chk("ar_arsize", 128'(arsize), 128'(3'b010));
            chk("ar_arburst", 128'(arburst), 128'(2'b01));
            chk("ar_rready", 128'(rready), 128'(0));
            chk("ar_no_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(0));
        end
        for (int k = 0; k < beats; k++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin
                @(negedge clk_g);
                n++;
                arready = 1'b0;
                rvalid  = 1'b0;
                #1;
                chk("gap_rready", 128'(rready), 128'(1));
                chk("gap_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(0));
            end
            @(negedge clk_g);
            n++;
            arready = 1'b0;
            word    = use_fix ? fix_data[k] : $urandom;
            rvalid  = 1'b1;
            rdata   = word;
            rid     = win_d ? 4'd1 : 4'd0;
            rresp   = 2'($urandom);
            rlast   = (k == beats - 1);
            if (abort_beat == k + 1) begin
                resetn = 1'b0;
                #1;
                chk("abort_arvalid", 128'(arvalid), 128'(0));
                chk("abort_rready", 128'(rready), 128'(0));
                chk("abort_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(0));
                chk("abort_ret_data", d_ret_data, 128'(0));
                m_buf    = '0;
                m_last_d = 1'b0;
                rvalid   = 1'b0;
                rlast    = 1'b0;
                i_rd_req = 1'b0;
                d_rd_req = 1'b0;
                return;
            end
            #1;
            chk("r_rready", 128'(rready), 128'(1));
            chk("r_arvalid", 128'(arvalid), 128'(0));
            chk("r_no_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(0));
            m_buf = {word, m_buf[127:32]};
        end
        @(negedge clk_g);
        n++;
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("done_i_ret_valid", 128'(i_ret_valid), 128'(!win_d));
        chk("done_d_ret_valid", 128'(d_ret_valid), 128'(win_d));
        chk("done_i_ret_data", i_ret_data, m_buf);
        chk("done_d_ret_data", d_ret_data, m_buf);
        chk("done_rready", 128'(rready), 128'(0));
        chk("done_arvalid", 128'(arvalid), 128'(0));
        if (ar_delay == 0 && gap_max == 0) chk("latency", 128'(n), 128'(beats + 2));
    endtask

    initial begin
        int  w;
        bit  wi, wd;
        resetn = 1'b0;
        i_rd_req = 1'b0; i_rd_uncache = 1'b0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_uncache = 1'b0; d_rd_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        use_fix = 1'b0;
        do_reset();

        // Cached icache line refill with fixed data, zero-wait slave.
        use_fix = 1'b1;
        fix_data[0] = 32'hA; fix_data[1] = 32'hB; fix_data[2] = 32'hC; fix_data[3] = 32'hD;
        do_round(1, 0, 32'h1fc0_0010, 0, 0, 32'h0, 0, 0, 0, w);
        chk("line_data", i_ret_data, 128'h0000000D_0000000C_0000000B_0000000A);

        // Uncached icache fetch: two beats in the top half.
        fix_data[0] = 32'h11; fix_data[1] = 32'h22;
        do_round(1, 1, 32'hbfc0_0004, 0, 0, 32'h0, 0, 0, 0, w);
        chk("i_uc_data", 128'(i_ret_data[127:64]), 128'(64'h00000022_00000011));
        use_fix = 1'b0;

        // First tie after reset goes to dcache; icache follows with no wait.
        do_reset();
        do_round(1, 0, 32'h0000_1000, 1, 0, 32'h0000_2000, 0, 0, 0, w);
        chk("tie_first_d", 128'(m_last_d), 128'(1));
        do_round(1, 0, 32'h0000_1000, 0, 0, 32'h0, 0, 0, 0, w);
        chk("loser_next_idle", 128'(w), 128'(0));

        // Repeated ties alternate.
        for (int r = 0; r < 8; r++) begin
            do_round(1, 1'($urandom), $urandom, 1, 1'($urandom), $urandom, 0, 0, 0, w);
        end

        // Long AR stall with the other port waiting, plus R gaps.
        do_reset();
        do_round(1, 0, 32'h1234_5670, 1, 0, 32'h8765_4320, 10, 2, 0, w);
        do_round(1, 0, 32'h1234_5670, 0, 0, 32'h0, 10, 2, 0, w);

        // Randomized traffic.
        for (int r = 0; r < 24; r++) begin
            wi = 1'($urandom);
            wd = 1'($urandom);
            if (!wi && !wd) wi = 1'b1;
            do_round(wi, 1'($urandom), $urandom, wd, 1'($urandom), $urandom,
                     int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), 0, w);
        end

        // Reset during beat 2 of a line refill, then a normal request.
        do_reset();
        do_round(1, 0, 32'h0000_4000, 0, 0, 32'h0, 0, 0, 2, w);
        @(negedge clk_g);
        resetn = 1'b1;
        do_round(0, 0, 32'h0, 1, 0, 32'h0000_5000, 0, 0, 0, w);
        do_round(1, 1, 32'h0000_6000, 0, 0, 32'h0, 0, 0, 0, w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_axi_rd_arbiter
`default_nettype wire
